// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock period meter and its edge detector.
package clk_meas_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    // Increment val by one, saturating at the all-ones value of the given width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_v;
        max_v   = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sat_inc = (val >= max_v) ? max_v : val + 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with registered previous level and edge decode.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    // Shift the asynchronous input through the synchronizer and keep the last level.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of a slow signal in clk_in cycles,
// with a sticky timeout when the signal stops toggling.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 27000000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] high_tmp;
    logic             rise;
    logic             fall;
    logic             edge_c;
    logic             to_hit_c;
    logic             sync_lvl_unused;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .sig_in (sig_in),
        .s      (sync_lvl_unused),
        .rise   (rise),
        .fall   (fall)
    );

    assign edge_c   = rise | fall;
    // An edge in the same cycle always beats the timeout.
    assign to_hit_c = (state != ST_IDLE) && (run_cnt == TIMEOUT_V) && !edge_c;

    // Cycles since the last edge; cleared while idle and on timeout.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (!enable || state == ST_IDLE) begin
            run_cnt <= '0;
        end else if (edge_c) begin
            run_cnt <= CNT_W'(1);
        end else if (to_hit_c) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= CNT_W'(sat_inc(64'(run_cnt), CNT_W));
        end
    end

    // Measurement FSM with registered results, strobe, timeout and busy.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            high_tmp   <= '0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ARM;
                        busy  <= 1'b1;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            state <= ST_HIGH;
                        end else if (to_hit_c) begin
                            timeout <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            high_tmp <= run_cnt;
                            state    <= ST_LOW;
                        end else if (to_hit_c) begin
                            timeout <= 1'b1;
                            state   <= ST_ARM;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            high_cnt   <= high_tmp;
                            low_cnt    <= run_cnt;
                            period_cnt <= high_tmp + run_cnt;
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            state      <= ST_HIGH;
                        end else if (to_hit_c) begin
                            timeout <= 1'b1;
                            state   <= ST_ARM;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
